// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus interconnect: round-robin arbitration of cache requests, snoop broadcast,
// shared-response OR-reduction, one memory handshake and a response back to the requester.
module snoop_bus_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned ID_W     = $clog2(NUM_CORES)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [2*NUM_CORES-1:0]      i_req_cmd,
  input  logic [ADDR_W*NUM_CORES-1:0] i_req_addr,
  input  logic [DATA_W*NUM_CORES-1:0] i_req_wdata,
  output logic [NUM_CORES-1:0]        o_gnt,
  output logic                        o_bus_valid,
  output logic [1:0]                  o_bus_cmd,
  output logic [ADDR_W-1:0]           o_bus_addr,
  output logic [ID_W-1:0]             o_bus_src,
  input  logic [NUM_CORES-1:0]        i_snoop_shared,
  output logic                        o_mem_req,
  output logic                        o_mem_we,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  input  logic                        i_mem_ack,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_resp_valid,
  output logic [ID_W-1:0]             o_resp_id,
  output logic [DATA_W-1:0]           o_resp_data,
  output logic                        o_resp_shared
);

  localparam logic [1:0] CmdNone = 2'b00;
  localparam logic [1:0] CmdRdMs = 2'b01;
  localparam logic [1:0] CmdWrBk = 2'b11;

  typedef enum logic [2:0] {StIdle, StBcast, StSnoop, StMem, StResp} state_e;

  state_e              r_state;
  logic [ID_W-1:0]     r_last;
  logic [ID_W-1:0]     r_id;
  logic [1:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_shared;

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_found_hi;
  logic                 w_found_lo;
  logic [ID_W-1:0]      w_win_hi;
  logic [ID_W-1:0]      w_win_lo;
  logic [ID_W-1:0]      w_winner;
  logic                 w_any;
  logic [1:0]           w_cmd;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;
  logic [NUM_CORES-1:0] w_others;

  always_comb begin
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      w_elig[i] = i_req[i] && (i_req_cmd[2*i +: 2] != CmdNone);
    end
  end

  // Round-robin: lowest eligible index above r_last wins, else lowest eligible at or below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        if (i > int'(r_last)) begin
          w_found_hi = 1'b1;
          w_win_hi   = ID_W'(i);
        end else begin
          w_found_lo = 1'b1;
          w_win_lo   = ID_W'(i);
        end
      end
    end
    w_winner = w_found_hi ? w_win_hi : w_win_lo;
    w_any    = w_found_hi || w_found_lo;
  end

  always_comb begin
    w_cmd   = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (w_winner == ID_W'(i)) begin
        w_cmd   = i_req_cmd[2*i +: 2];
        w_addr  = i_req_addr[ADDR_W*i +: ADDR_W];
        w_wdata = i_req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // The requester's own snoop response never counts as another sharer.
  assign w_others = i_snoop_shared & ~(NUM_CORES'(1) << r_id);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_last        <= ID_W'(NUM_CORES - 1);
      r_id          <= '0;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_shared      <= 1'b0;
      o_gnt         <= '0;
      o_bus_valid   <= 1'b0;
      o_bus_cmd     <= '0;
      o_bus_addr    <= '0;
      o_bus_src     <= '0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_resp_valid  <= 1'b0;
      o_resp_id     <= '0;
      o_resp_data   <= '0;
      o_resp_shared <= 1'b0;
    end else begin
      o_gnt        <= '0;
      o_resp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_id        <= w_winner;
            r_last      <= w_winner;
            r_cmd       <= w_cmd;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            o_gnt       <= NUM_CORES'(1) << w_winner;
            o_bus_valid <= 1'b1;
            o_bus_cmd   <= w_cmd;
            o_bus_addr  <= w_addr;
            o_bus_src   <= w_winner;
            r_state     <= StBcast;
          end
        end
        StBcast: begin
          r_state <= StSnoop;
        end
        StSnoop: begin
          r_shared    <= |w_others;
          o_bus_valid <= 1'b0;
          o_mem_req   <= 1'b1;
          o_mem_we    <= (r_cmd == CmdWrBk);
          o_mem_addr  <= r_addr;
          o_mem_wdata <= (r_cmd == CmdWrBk) ? r_wdata : '0;
          r_state     <= StMem;
        end
        StMem: begin
          if (i_mem_ack) begin
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_resp_valid  <= 1'b1;
            o_resp_id     <= r_id;
            o_resp_data   <= (r_cmd == CmdWrBk) ? r_wdata : i_mem_rdata;
            o_resp_shared <= (r_cmd == CmdRdMs) && r_shared;
            r_state       <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed scenarios plus random traffic, with a round-robin
// reference model and a response scoreboard drained by an independent monitor.
module tb_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam logic [1:0] RDMS = 2'b01;
  localparam logic [1:0] WRMS = 2'b10;
  localparam logic [1:0] WRBK = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_drv = '0;
  logic [1:0]      cmd_drv   [N];
  logic [AW-1:0]   addr_drv  [N];
  logic [DW-1:0]   wdata_drv [N];
  logic [2*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic [N-1:0]    snoop = '0;
  logic            mem_ack = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  logic [N-1:0]  gnt;
  logic          bus_valid, mem_req, mem_we, resp_valid, resp_shared;
  logic [1:0]    bus_cmd;
  logic [AW-1:0] bus_addr, mem_addr;
  logic [IW-1:0] bus_src, resp_id;
  logic [DW-1:0] mem_wdata, resp_data;

  snoop_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req_drv), .i_req_cmd(req_cmd), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_gnt(gnt), .o_bus_valid(bus_valid), .o_bus_cmd(bus_cmd),
    .o_bus_addr(bus_addr), .o_bus_src(bus_src), .i_snoop_shared(snoop), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .o_resp_valid(resp_valid), .o_resp_id(resp_id),
    .o_resp_data(resp_data), .o_resp_shared(resp_shared)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_cmd[2*i +: 2]     = cmd_drv[i];
      req_addr[AW*i +: AW]  = addr_drv[i];
      req_wdata[DW*i +: DW] = wdata_drv[i];
    end
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    bit            shared;
    int            cyc;
  } resp_t;
  resp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            last_w = N - 1;
  int            phase = -1;  // -1 idle, 0 bcast seen, 1 snoop driven, 2 in mem, 3 acked
  int            cur_w, wcnt, mem_hi_cnt;
  logic [1:0]    cur_cmd;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  bit            exp_shared, exp_gnt_next, dut_idle;
  int            glog[$];

  // Knobs
  int            auto_mode = 0;
  bit            snoop_fix_en = 1'b0;
  logic [N-1:0]  snoop_fix = '0;
  int            ack_wait = 0;
  bit            rdata_fix_en = 1'b0;
  logic [DW-1:0] rdata_fix = '0;
  bit            stray = 1'b0;

  int            last_rid = -1;
  logic [DW-1:0] last_rdata = '0;
  bit            last_rshared = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] elig_vec();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = req_drv[i] && (cmd_drv[i] != 2'b00);
    return e;
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] e);
    for (int k = 1; k <= N; k++) begin
      if (e[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit is_busy(input int c);
    if (phase >= 0 && phase <= 2 && cur_w == c) return 1'b1;
    foreach (sb[k]) if (sb[k].id == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic raise(input int c, input logic [1:0] cmd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_drv[c]   = 1'b1;
    cmd_drv[c]   = cmd;
    addr_drv[c]  = a;
    wdata_drv[c] = d;
  endtask

  task automatic arm();
    exp_gnt_next = dut_idle && (elig_vec() != '0);
  endtask

  task automatic step();
    logic [N-1:0] el;
    int ew, r;
    bit acked, snoop_set, in_idle;
    resp_t t;
    @(negedge clk);
    acked = 0;
    snoop_set = 0;
    el = elig_vec();
    in_idle = (phase == -1) && (gnt == '0);
    if (gnt != '0) begin
      chk("gnt_expected", 64'(exp_gnt_next), 64'(1));
      chk("gnt_onehot", 64'($onehot(gnt)), 64'(1));
      ew = rr_pick(last_w, el);
      if (ew >= 0) begin
        chk("gnt_winner", 64'(gnt), 64'(N'(1) << ew));
        chk("bus_valid_bcast", 64'(bus_valid), 64'(1));
        chk("bus_src", 64'(bus_src), 64'(ew));
        chk("bus_cmd", 64'(bus_cmd), 64'(cmd_drv[ew]));
        chk("bus_addr", 64'(bus_addr), 64'(addr_drv[ew]));
        cur_w = ew;
        cur_cmd = cmd_drv[ew];
        cur_addr = addr_drv[ew];
        cur_wdata = wdata_drv[ew];
        req_drv[ew] = 1'b0;
        last_w = ew;
        glog.push_back(ew);
        phase = 0;
        mem_hi_cnt = 0;
      end
    end else begin
      if (exp_gnt_next) chk("gnt_latency", 64'(gnt), 64'(N'(1) << rr_pick(last_w, el)));
      case (phase)
        0: begin
          chk("bus_valid_snoop", 64'(bus_valid), 64'(1));
          chk("bus_src_snoop", 64'(bus_src), 64'(cur_w));
          snoop = snoop_fix_en ? snoop_fix : N'($urandom);
          snoop_set = 1;
          exp_shared = (cur_cmd == RDMS) && ((snoop & ~(N'(1) << cur_w)) != '0);
          phase = 1;
        end
        1, 2: begin
          chk("mem_req", 64'(mem_req), 64'(1));
          mem_hi_cnt++;
          if (phase == 1) begin
            chk("bus_valid_off", 64'(bus_valid), 64'(0));
            chk("mem_we", 64'(mem_we), 64'(cur_cmd == WRBK));
            chk("mem_addr", 64'(mem_addr), 64'(cur_addr));
            chk("mem_wdata", 64'(mem_wdata), (cur_cmd == WRBK) ? 64'(cur_wdata) : 64'(0));
            wcnt = (ack_wait >= 0) ? ack_wait : int'($urandom_range(0, 3));
            phase = 2;
          end
          if (wcnt == 0) begin
            mem_ack = 1'b1;
            mem_rdata = rdata_fix_en ? rdata_fix : $urandom;
            t.id = cur_w;
            t.data = (cur_cmd == WRBK) ? cur_wdata : mem_rdata;
            t.shared = exp_shared;
            t.cyc = cyc + 1;
            sb.push_back(t);
            acked = 1;
            phase = 3;
          end else begin
            wcnt--;
          end
        end
        3: begin
          chk("mem_req_drop", 64'(mem_req), 64'(0));
          phase = -1;
        end
        default: chk("mem_req_idle", 64'(mem_req), 64'(0));
      endcase
    end
    if (!snoop_set) snoop = N'($urandom);
    if (!acked) mem_ack = (stray && phase != 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!is_busy(i) && !el[i] && !(gnt != '0 && cur_w == i)) begin
        if (auto_mode == 2) begin
          raise(i, RDMS, $urandom, $urandom);
        end else if (auto_mode == 1) begin
          r = int'($urandom_range(0, 7));
          if (r < 2) raise(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
          else if (r == 2) req_drv[i] = 1'b0;
        end
      end
    end
    dut_idle = in_idle;
    exp_gnt_next = in_idle && (elig_vec() != '0);
  endtask

  // Scoreboard monitor: expects a response exactly in the cycle the model recorded.
  bit    mon_exp;
  resp_t mon_r;
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
      mon_exp = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("resp_valid", 64'(resp_valid), 64'(mon_exp));
      if (mon_exp) begin
        mon_r = sb.pop_front();
        chk("resp_id", 64'(resp_id), 64'(mon_r.id));
        chk("resp_data", 64'(resp_data), 64'(mon_r.data));
        chk("resp_shared", 64'(resp_shared), 64'(mon_r.shared));
        last_rid = mon_r.id;
        last_rdata = mon_r.data;
        last_rshared = mon_r.shared;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_drv = '0;
    mem_ack = 1'b0;
    snoop = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt_bus", 64'({gnt, bus_valid, bus_cmd, bus_src}), 64'(0));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_mem_ctl", 64'({mem_req, mem_we}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_resp_ctl", 64'({resp_valid, resp_id, resp_shared}), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    phase = -1;
    sb.delete();
    last_w = N - 1;
    exp_gnt_next = 0;
    dut_idle = 1;
  endtask

  task automatic drain();
    bit done;
    auto_mode = 0;
    for (int i = 0; i < N; i++) if (cmd_drv[i] == 2'b00) req_drv[i] = 1'b0;
    done = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (dut_idle && sb.size() == 0 && elig_vec() == '0 && !exp_gnt_next) begin
        done = 1;
        break;
      end
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++) begin
      cmd_drv[i] = 2'b00;
      addr_drv[i] = '0;
      wdata_drv[i] = '0;
    end
    do_reset();

    // Single RdMs from core 2 with another sharer
    snoop_fix_en = 1; snoop_fix = 4'b0010; ack_wait = 0;
    rdata_fix_en = 1; rdata_fix = 32'hDEADBEEF;
    raise(2, RDMS, 32'h1000, 32'h0);
    arm();
    step();
    chk("t1_gnt", 64'(gnt), 64'(4'b0100));
    drain();
    chk("t1_rid", 64'(last_rid), 64'(2));
    chk("t1_rdata", 64'(last_rdata), 64'(32'hDEADBEEF));
    chk("t1_shared", 64'(last_rshared), 64'(1));

    // Own bit is not a sharer
    raise(1, RDMS, 32'h2000, 32'h0);
    arm();
    drain();
    chk("t2_rid", 64'(last_rid), 64'(1));
    chk("t2_shared", 64'(last_rshared), 64'(0));

    // Round-robin with all cores requesting continuously
    do_reset();
    glog.delete();
    snoop_fix_en = 0; rdata_fix_en = 0;
    auto_mode = 2;
    for (int k = 0; k < 80 && glog.size() < 5; k++) step();
    drain();
    chk("t3_count", 64'(glog.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < glog.size(); k++) chk("t3_order", 64'(glog[k]), 64'(exp_order[k]));

    // Write-back with delayed ack
    ack_wait = 5;
    raise(3, WRBK, 32'h20, 32'h55AA);
    arm();
    drain();
    chk("t4_mem_cycles", 64'(mem_hi_cnt), 64'(6));
    chk("t4_data", 64'(last_rdata), 64'(32'h55AA));
    chk("t4_shared", 64'(last_rshared), 64'(0));

    // WrMs with every core sharing, stray acks around it
    ack_wait = 1; snoop_fix_en = 1; snoop_fix = 4'b1111; stray = 1;
    raise(0, WRMS, 32'h300, 32'h0);
    arm();
    drain();
    chk("t5_rid", 64'(last_rid), 64'(0));
    chk("t5_shared", 64'(last_rshared), 64'(0));
    repeat (6) step();
    stray = 0;

    // Reset while the memory transaction is outstanding
    ack_wait = 20;
    raise(2, RDMS, 32'h4000, 32'h0);
    arm();
    for (int k = 0; k < 10; k++) begin
      step();
      if (mem_req) break;
    end
    chk("t6_in_mem", 64'(mem_req), 64'(1));
    do_reset();
    ack_wait = 0;
    raise(3, RDMS, 32'h5000, 32'h0);
    raise(0, RDMS, 32'h6000, 32'h0);
    arm();
    step();
    chk("t6_gnt0", 64'(gnt), 64'(4'b0001));
    drain();

    // Random traffic
    snoop_fix_en = 0; ack_wait = -1; stray = 1;
    auto_mode = 1;
    repeat (600) step();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
